// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register slice.
// Provides the stage-action encoding, stall-bit polarity names and a
// saturating-increment helper used by the performance counters.
package pipe_pkg;

    // Action taken by the stage register on the last clock edge
    typedef enum logic [1:0] {
        ST_PASS   = 2'b00,
        ST_BUBBLE = 2'b01,
        ST_HOLD   = 2'b10,
        ST_CLEAR  = 2'b11
    } stage_e;

    // Polarity of the ctrl stall bits
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Widest counter the helper supports
    localparam int unsigned SAT_MAX_W = 64;

    // Increment v, sticking at the all-ones value of a w-bit counter
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] v,
        input int unsigned          w
    );
        logic [SAT_MAX_W-1:0] top;
        top = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
        return (v >= top) ? v : v + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset, clears q
//   clr   - synchronous clear, wins over inc
//   inc   - count enable, +1 per edge, sticks at all-ones
//   q     - registered count
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_nxt;

    // Next count: clear beats increment
    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (inc) begin
            q_nxt = W'(sat_inc(SAT_MAX_W'(q), W));
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register for the 5-stage MIPS core.
// Carries a payload, a multi-cycle carry field and an iteration count,
// and supports flush, bubble insertion and hold. Also reports the action
// taken each edge and keeps bubble/hold performance counters plus a
// sticky stall-timeout watchdog.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   flush                  - clears the stage (overrides stalls)
//   stall_cur, stall_nxt   - ctrl stall bits of feeding / downstream stage
//   in_valid, in_payload   - upstream instruction
//   in_carry, in_cnt       - multi-cycle temp and iteration index
//   perf_clr               - clears counters and watchdog
//   out_*                  - registered stage contents
//   stage_state            - action on last edge (PASS/BUBBLE/HOLD/CLEAR)
//   bubble_cnt, hold_run   - saturating bubble count, current hold run
//   hold_timeout           - sticky watchdog flag
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned CARRY_W   = 64,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned PERF_W    = 16,
    parameter int unsigned HOLD_MAX  = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 stall_cur,
    input  logic                 stall_nxt,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CARRY_W-1:0]   in_carry,
    input  logic [CNT_W-1:0]     in_cnt,
    input  logic                 perf_clr,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CARRY_W-1:0]   out_carry,
    output logic [CNT_W-1:0]     out_cnt,
    output logic [1:0]           stage_state,
    output logic [PERF_W-1:0]    bubble_cnt,
    output logic [PERF_W-1:0]    hold_run,
    output logic                 hold_timeout
);

    stage_e                 state_q;
    stage_e                 state_nxt;
    logic                   valid_nxt;
    logic [PAYLOAD_W-1:0]   payload_nxt;
    logic [CARRY_W-1:0]     carry_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   is_bubble_c;
    logic                   is_hold_c;
    logic [PERF_W-1:0]      hold_run_nxt_c;
    logic                   timeout_nxt;

    // Action select and stage contents for the coming edge
    always_comb begin
        state_nxt   = ST_PASS;
        valid_nxt   = out_valid;
        payload_nxt = out_payload;
        carry_nxt   = out_carry;
        cnt_nxt     = out_cnt;
        if (flush) begin
            state_nxt   = ST_CLEAR;
            valid_nxt   = 1'b0;
            payload_nxt = '0;
            carry_nxt   = '0;
            cnt_nxt     = '0;
        end else if (stall_cur == Stop && stall_nxt == NoStop) begin
            // Downstream runs on: emit a bubble but keep the multi-cycle state
            state_nxt   = ST_BUBBLE;
            valid_nxt   = 1'b0;
            payload_nxt = '0;
            carry_nxt   = in_carry;
            cnt_nxt     = in_cnt;
        end else if (stall_cur == Stop) begin
            state_nxt = ST_HOLD;
        end else begin
            state_nxt   = ST_PASS;
            valid_nxt   = in_valid;
            payload_nxt = in_payload;
            carry_nxt   = '0;
            cnt_nxt     = '0;
        end
    end

    assign is_bubble_c = (state_nxt == ST_BUBBLE);
    assign is_hold_c   = (state_nxt == ST_HOLD);

    // Mirror of the hold counter's next value, needed to trip the watchdog
    // on the same edge the run reaches HOLD_MAX
    always_comb begin
        hold_run_nxt_c = '0;
        if (!perf_clr && is_hold_c) begin
            hold_run_nxt_c = PERF_W'(sat_inc(SAT_MAX_W'(hold_run), PERF_W));
        end
    end

    // Sticky watchdog: clear beats trip
    always_comb begin
        timeout_nxt = hold_timeout;
        if (perf_clr) begin
            timeout_nxt = 1'b0;
        end else if (hold_run_nxt_c == PERF_W'(HOLD_MAX)) begin
            timeout_nxt = 1'b1;
        end
    end

    // Stage state and contents registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            out_valid    <= 1'b0;
            out_payload  <= '0;
            out_carry    <= '0;
            out_cnt      <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            out_valid    <= valid_nxt;
            out_payload  <= payload_nxt;
            out_carry    <= carry_nxt;
            out_cnt      <= cnt_nxt;
            hold_timeout <= timeout_nxt;
        end
    end

    assign stage_state = state_q;

    // Bubble counter survives flush; only perf_clr or reset clears it
    sat_counter #(
        .W (PERF_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (is_bubble_c),
        .q     (bubble_cnt)
    );

    // Hold run length restarts on any non-HOLD edge
    sat_counter #(
        .W (PERF_W)
    ) u_hold_run (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr | ~is_hold_c),
        .inc   (is_hold_c),
        .q     (hold_run)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a directed vector table, hand
// sequences for counter saturation, then randomized traffic against a
// behavioural model. Uses PERF_W=3 and HOLD_MAX=4 so saturation and the
// watchdog are reachable in a few cycles.
module tb_pipe_stage_reg;

    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned CARRY_W   = 64;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned PERF_W    = 3;
    localparam int unsigned HOLD_MAX  = 4;
    localparam int          PMAX      = 7;

    logic                 clk = 1'b0;
    logic                 rst_n, flush, stall_cur, stall_nxt, in_valid, perf_clr;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [CARRY_W-1:0]   in_carry;
    logic [CNT_W-1:0]     in_cnt;
    logic                 out_valid, hold_timeout;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CARRY_W-1:0]   out_carry;
    logic [CNT_W-1:0]     out_cnt;
    logic [1:0]           stage_state;
    logic [PERF_W-1:0]    bubble_cnt, hold_run;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .CARRY_W   (CARRY_W),
        .CNT_W     (CNT_W),
        .PERF_W    (PERF_W),
        .HOLD_MAX  (HOLD_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .stall_cur    (stall_cur),
        .stall_nxt    (stall_nxt),
        .in_valid     (in_valid),
        .in_payload   (in_payload),
        .in_carry     (in_carry),
        .in_cnt       (in_cnt),
        .perf_clr     (perf_clr),
        .out_valid    (out_valid),
        .out_payload  (out_payload),
        .out_carry    (out_carry),
        .out_cnt      (out_cnt),
        .stage_state  (stage_state),
        .bubble_cnt   (bubble_cnt),
        .hold_run     (hold_run),
        .hold_timeout (hold_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, flush, sc, sn, iv;
        logic [31:0] pay;
        logic [63:0] carry;
        logic [1:0]  cnt;
        logic        pc;
        logic        ev;
        logic [31:0] ep;
        logic [63:0] ec;
        logic [1:0]  ecnt;
        logic [1:0]  est;
        int          eb, eh;
        logic        eto;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs, input logic fl, input logic sc, input logic sn, input logic iv,
        input logic [31:0] pay, input logic [63:0] carry, input logic [1:0] cnt, input logic pc,
        input logic ev, input logic [31:0] ep, input logic [63:0] ec, input logic [1:0] ecnt,
        input logic [1:0] est, input int eb, input int eh, input logic eto);
        vec_t v;
        v.rst_n = rs; v.flush = fl; v.sc = sc; v.sn = sn; v.iv = iv;
        v.pay = pay; v.carry = carry; v.cnt = cnt; v.pc = pc;
        v.ev = ev; v.ep = ep; v.ec = ec; v.ecnt = ecnt; v.est = est;
        v.eb = eb; v.eh = eh; v.eto = eto;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ep,
                             input logic [63:0] ec, input logic [1:0] ecnt, input logic [1:0] est,
                             input int eb, input int eh, input logic eto);
        check({tag, ".out_valid"},    64'(out_valid),    64'(ev));
        check({tag, ".out_payload"},  64'(out_payload),  64'(ep));
        check({tag, ".out_carry"},    out_carry,         ec);
        check({tag, ".out_cnt"},      64'(out_cnt),      64'(ecnt));
        check({tag, ".stage_state"},  64'(stage_state),  64'(est));
        check({tag, ".bubble_cnt"},   64'(bubble_cnt),   64'(eb));
        check({tag, ".hold_run"},     64'(hold_run),     64'(eh));
        check({tag, ".hold_timeout"}, 64'(hold_timeout), 64'(eto));
    endtask

    task automatic drive(input logic rs, input logic fl, input logic sc, input logic sn,
                         input logic iv, input logic [31:0] pay, input logic [63:0] carry,
                         input logic [1:0] cnt, input logic pc);
        rst_n = rs; flush = fl; stall_cur = sc; stall_nxt = sn; in_valid = iv;
        in_payload = pay; in_carry = carry; in_cnt = cnt; perf_clr = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state
    logic        m_v, m_to;
    logic [31:0] m_p;
    logic [63:0] m_c;
    logic [1:0]  m_n, m_st;
    int          m_b, m_h;

    // One edge of the model, from the action priority rules
    task automatic model_step();
        int act;
        if (!rst_n) begin
            m_v = 0; m_p = 0; m_c = 0; m_n = 0; m_st = 2'd3; m_b = 0; m_h = 0; m_to = 0;
            return;
        end
        if (flush)                   act = 3;
        else if (stall_cur && !stall_nxt) act = 1;
        else if (stall_cur)          act = 2;
        else                         act = 0;
        case (act)
            3: begin m_v = 0; m_p = 0; m_c = 0; m_n = 0; end
            1: begin m_v = 0; m_p = 0; m_c = in_carry; m_n = in_cnt; end
            2: ;
            default: begin m_v = in_valid; m_p = in_payload; m_c = 0; m_n = 0; end
        endcase
        m_st = 2'(act);
        if (perf_clr)      m_b = 0;
        else if (act == 1) m_b = (m_b + 1 > PMAX) ? PMAX : m_b + 1;
        if (perf_clr || act != 2) m_h = 0;
        else                      m_h = (m_h + 1 > PMAX) ? PMAX : m_h + 1;
        if (perf_clr)                  m_to = 0;
        else if (m_h == int'(HOLD_MAX)) m_to = 1;
    endtask

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, then reset arriving in the middle of a hold run
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,  0,0,0,0,3, 0,0,0));
        vecs.push_back(mk(1,0,0,0,1, 32'h11,64'h55,1,0,  1,32'h11,0,0,0, 0,0,0));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(1,0,1,1,0, 32'hFF,64'hAA,3,0,  1,32'h11,0,0,2, 0,k,k >= 4));
        vecs.push_back(mk(0,0,1,1,1, 32'hFF,64'hAA,3,0,  0,0,0,0,3, 0,0,0));
        // PASS: carry/cnt are dropped
        vecs.push_back(mk(1,0,0,0,1, 32'hA5A5_0001,64'h1234,2,0,  1,32'hA5A5_0001,0,0,0, 0,0,0));
        // Bubbles keep the multi-cycle state
        for (int k = 1; k <= 4; k++)
            vecs.push_back(mk(1,0,1,0,1, 32'hBB,DB,1,0,  0,0,DB,1,1, k,0,0));
        // Hold then flush under stall
        vecs.push_back(mk(1,0,0,0,1, 32'h77,64'h9,3,0,  1,32'h77,0,0,0, 4,0,0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(mk(1,0,1,1,0, 32'h0,64'h3,2,0,  1,32'h77,0,0,2, 4,k,0));
        vecs.push_back(mk(1,1,1,1,1, 32'h66,64'h5,1,0,  0,0,0,0,3, 4,0,0));
        // Watchdog trips on the 4th hold, survives PASS and flush
        for (int k = 1; k <= 4; k++)
            vecs.push_back(mk(1,0,1,1,1, 32'h66,64'h5,1,0,  0,0,0,0,2, 4,k,k == 4));
        vecs.push_back(mk(1,0,0,0,1, 32'h99,64'h5,1,0,  1,32'h99,0,0,0, 4,0,1));
        vecs.push_back(mk(1,1,0,0,1, 32'h99,64'h5,1,0,  0,0,0,0,3, 4,0,1));
        // perf_clr clears counters and watchdog
        vecs.push_back(mk(1,0,0,0,0, 32'h05,64'h5,1,1,  0,32'h05,0,0,0, 0,0,0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(mk(1,0,1,1,0, 32'h1,64'h2,0,0,  0,32'h05,0,0,2, 0,k,0));
        vecs.push_back(mk(1,0,1,1,0, 32'h1,64'h2,0,1,  0,32'h05,0,0,2, 0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 32'h1,64'h2,0,0,  0,32'h05,0,0,2, 0,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].sc, vecs[i].sn, vecs[i].iv,
                  vecs[i].pay, vecs[i].carry, vecs[i].cnt, vecs[i].pc);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ep, vecs[i].ec, vecs[i].ecnt,
                      vecs[i].est, vecs[i].eb, vecs[i].eh, vecs[i].eto);
        end

        // Bubble counter saturation and clear-on-bubble
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check("sat.pre_clr", 64'(bubble_cnt), 64'd0);
        for (int i = 1; i <= 9; i++) begin
            drive(1, 0, 1, 0, 0, 0, 64'(i), 0, 0);
            tick();
            check($sformatf("sat.bubble%0d", i), 64'(bubble_cnt), 64'((i > PMAX) ? PMAX : i));
        end
        drive(1, 0, 1, 0, 0, 0, 0, 0, 1);
        tick();
        check("sat.clr_with_bubble", 64'(bubble_cnt), 64'd0);
        check("sat.clr_state", 64'(stage_state), 64'd1);

        // Hold run saturation, watchdog stays set
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
            tick();
            check($sformatf("hsat.run%0d", i), 64'(hold_run), 64'((i > PMAX) ? PMAX : i));
            check($sformatf("hsat.to%0d", i), 64'(hold_timeout), 64'(i >= int'(HOLD_MAX)));
        end

        // Randomized traffic against the model
        m_v = 0; m_p = 0; m_c = 0; m_n = 0; m_st = 0; m_b = 0; m_h = 0; m_to = 0;
        for (int i = 0; i < 800; i++) begin
            drive((i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) != 0),
                  1'($urandom()),
                  $urandom(),
                  {$urandom(), $urandom()},
                  2'($urandom()),
                  ($urandom_range(0, 23) == 0));
            model_step();
            tick();
            check_all($sformatf("rnd%0d", i), m_v, m_p, m_c, m_n, m_st, m_b, m_h, m_to);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core; next generation of the fixed-field stage latches.
- Carries an opaque payload, a multi-cycle carry field (for example the MADD/DIV temp result) and an iteration count.
- Supports flush, bubble insertion and hold.
- Adds a valid bit, a stage-state report, saturating bubble/hold performance counters and a stall-timeout watchdog.

Parameters:
- PAYLOAD_W, 32: width of the pass-through payload (op, regaddr, result, hi/lo, etc. concatenated by the instantiator).
- CARRY_W, 64: width of the multi-cycle temp field.
- CNT_W, 2: width of the multi-cycle iteration count.
- PERF_W, 16: width of the performance counters.
- HOLD_MAX, 255: consecutive-hold cycles that trip hold_timeout; must be ≥1 and < 2^PERF_W.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, synchronous, active-low.
- flush, input, 1: exception/branch flush; clears the stage.
- stall_cur, input, 1: the ctrl stall bit for the upstream (feeding) stage.
- stall_nxt, input, 1: the ctrl stall bit for this register's downstream stage.
- in_valid, input, 1: upstream instruction valid.
- in_payload, input, PAYLOAD_W: upstream payload.
- in_carry, input, CARRY_W: multi-cycle temp from the execute unit.
- in_cnt, input, CNT_W: multi-cycle iteration index.
- perf_clr, input, 1: synchronous clear of counters and timeout.
- out_valid, output, 1: registered valid.
- out_payload, output, PAYLOAD_W: registered payload.
- out_carry, output, CARRY_W: registered carry, fed back to the execute unit.
- out_cnt, output, CNT_W: registered count, fed back to the execute unit.
- stage_state, output, 2: action taken on the last edge. Encoding: 00 PASS, 01 BUBBLE, 10 HOLD, 11 CLEAR.
- bubble_cnt, output, PERF_W: saturating count of BUBBLE cycles.
- hold_run, output, PERF_W: current consecutive-HOLD length.
- hold_timeout, output, 1: sticky watchdog flag.

Behaviour:
- All outputs are registered and update on posedge clk. Latency is 1 cycle in → out.
- Per-edge action, in priority order:
  1. !rst_n → CLEAR. out_valid = 0, out_payload = 0, out_carry = 0, out_cnt = 0, stage_state = 11, bubble_cnt = 0, hold_run = 0, hold_timeout = 0.
  2. flush → CLEAR. Same register values as reset, except the perf counters are NOT cleared: bubble_cnt is kept, hold_run = 0, hold_timeout is kept. flush overrides any stall combination.
  3. stall_cur & !stall_nxt → BUBBLE. out_valid = 0, out_payload = 0, out_carry <= in_carry, out_cnt <= in_cnt (multi-cycle state preserved), stage_state = 01.
  4. stall_cur & stall_nxt → HOLD. out_valid, out_payload, out_carry and out_cnt all keep their values; stage_state = 10.
  5. !stall_cur → PASS. out_valid <= in_valid, out_payload <= in_payload, out_carry = 0, out_cnt = 0, stage_state = 00.
- A 4-state FSM {PASS, BUBBLE, HOLD, CLEAR} is held in stage_state. Any state may go to any state, decided solely by the priority above.
- bubble_cnt:
  - +1 on each BUBBLE edge, saturates at 2^PERF_W−1 (no wrap).
  - perf_clr on the same edge wins: result 0.
- hold_run:
  - +1 on each HOLD edge, saturating.
  - Set to 0 on any non-HOLD edge, or on perf_clr.
- hold_timeout:
  - Set on the edge where hold_run's next value == HOLD_MAX.
  - Sticky until perf_clr or reset.
  - perf_clr and a trip on the same edge: clear wins.
- The width of in_cnt/out_cnt is passed through untouched; no arithmetic is done on it.
- X-free: every register has a defined value for every input combination.

Decomposition:
- pipe_pkg holds:
  - ST_PASS/ST_BUBBLE/ST_HOLD/ST_CLEAR 2-bit constants.
  - Stop = 1'b1 and NoStop = 1'b0.
  - the helper function for saturating increment.
- One natural sub-module: sat_counter, with parameter W and ports clk, rst_n, clr, inc, q.
  - Instantiated for bubble_cnt (clr = perf_clr) and for hold_run (clr = perf_clr | !hold).

Test Plan:
1. Reset mid-HOLD: drive stall_cur = stall_nxt = 1 for 5 cycles with out_valid = 1, then rst_n = 0 for 1 edge → all outputs 0 and stage_state = 11 on the next cycle.
2. PASS stream: stall bits 0, in_valid = 1, in_payload = 0xA5A5_0001, in_carry = 0x1234 → next cycle out_valid = 1, out_payload = 0xA5A5_0001, out_carry = 0, out_cnt = 0, stage_state = 00.
3. Multi-cycle bubble: stall_cur = 1, stall_nxt = 0, in_carry = 0xDEAD_BEEF_0000_0001, in_cnt = 1 → out_valid = 0, out_payload = 0, out_carry = 0xDEAD_BEEF_0000_0001, out_cnt = 1, bubble_cnt = 1; after 3 further bubbles bubble_cnt = 4.
4. Hold then flush: PASS payload 0x77, hold 3 cycles (payload stays 0x77, hold_run = 3), then flush together with stall_cur = stall_nxt = 1 → CLEAR, out_valid = 0, hold_run = 0, bubble_cnt unchanged.
5. Watchdog with HOLD_MAX = 4: hold 4 cycles → hold_timeout = 1 on the 4th edge; release to PASS → hold_run = 0 and hold_timeout stays 1; perf_clr → hold_timeout = 0 and bubble_cnt = 0.
6. Saturation with PERF_W = 3: 9 consecutive BUBBLE edges → bubble_cnt = 7 (no wrap); perf_clr together with a BUBBLE edge → bubble_cnt = 0.
